// File: rtl/divmod_iter.sv
// divmod_iter: iterative restoring divider, signed/unsigned per op; define DIVMOD_ITER_EARLY_OUT_EN to skip leading zero bits of |a|
module divmod_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             error,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_init;
  logic [WIDTH-1:0] r_q, r_b, r_quo, r_rem;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_q_init, w_q_nxt, w_quo_fix, w_rem_fix;
  logic [WIDTH:0]   r_r, w_r_nxt;
  logic [WIDTH+1:0] w_sh, w_trial;
  logic             r_neg_q, r_neg_r, r_err, w_acc, w_short;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign error     = r_err;
  assign quo       = r_quo;
  assign rem       = r_rem;
  assign w_acc     = in_valid && in_ready;
  assign w_abs_a   = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b   = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_sh      = {r_r, r_q[WIDTH-1]};
  assign w_trial   = w_sh - {2'b00, r_b};
  assign w_r_nxt   = w_trial[WIDTH+1] ? w_sh[WIDTH:0] : w_trial[WIDTH:0];
  assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_trial[WIDTH+1]};
  assign w_quo_fix = r_neg_q ? -w_q_nxt : w_q_nxt;
  assign w_rem_fix = r_neg_r ? -w_r_nxt[WIDTH-1:0] : w_r_nxt[WIDTH-1:0];
`ifdef DIVMOD_ITER_EARLY_OUT_EN
  // priority encoder: index of the highest set bit of |a|
  always_comb begin
    w_cnt_init = '0;
    for (int i = 0; i < WIDTH; i++) if (w_abs_a[i]) w_cnt_init = CW'(i);
  end
  assign w_q_init = w_abs_a << (CW'(WIDTH - 1) - w_cnt_init);
  assign w_short  = (b == '0) || (w_abs_a == '0);
`else
  assign w_cnt_init = CW'(WIDTH - 1);
  assign w_q_init   = w_abs_a;
  assign w_short    = b == '0;
`endif
  // next-state: divide-by-zero (and zero dividend with early-out) bypass CALC
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE) ? (w_acc ? (w_short ? DONE : CALC) : IDLE) :
                  (r_state == CALC) ? ((r_cnt == '0) ? DONE : CALC) :
                  (out_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end
  // datapath: latch magnitudes at accept, one quotient bit per CALC cycle, sign fix-up on the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_err   <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
    end else if (w_acc) begin
      r_neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_r <= is_signed && a[WIDTH-1];
      r_b     <= w_abs_b;
      r_q     <= w_q_init;
      r_r     <= '0;
      r_cnt   <= w_cnt_init;
      if (w_short) begin
        r_err <= b == '0;
        r_quo <= (b == '0) ? '1 : '0;
        r_rem <= (b == '0) ? a : '0;
      end
    end else if (r_state == CALC) begin
      r_q   <= w_q_nxt;
      r_r   <= w_r_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == '0) begin
        r_err <= 1'b0;
        r_quo <= w_quo_fix;
        r_rem <= w_rem_fix;
      end
    end
  end
endmodule

// File: tb/tb_divmod_iter.sv
// tb_divmod_iter: randomized + directed check of divmod_iter against an arithmetic reference model
module tb_divmod_iter;
  localparam int W = 16;
  logic         clk, rst_n, in_valid, in_ready, is_signed, out_valid, out_ready, error;
  logic [W-1:0] a, b, quo, rem;
  int           n_cmp = 0, n_err = 0;

  divmod_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_signed(is_signed), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .error(error), .quo(quo), .rem(rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: plain truncating division on integers; latency in clock edges after accept
  task automatic model(input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] q, output logic [W-1:0] r, output bit e, output int lat);
    longint sx, sy, mx;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    mx = (sx < 0) ? -sx : sx;
    e  = (y == '0);
    if (e) begin
      q = '1;
      r = x;
    end else begin
      q = W'(sx / sy);
      r = W'(sx % sy);
    end
`ifdef DIVMOD_ITER_EARLY_OUT_EN
    lat = 0;
    while ((mx >> lat) != 0) lat++;
    if (e) lat = 0;
`else
    lat = e ? 0 : W;
    if (mx < 0) lat = -1;
`endif
  endtask

  task automatic run_op(input bit s, input logic [W-1:0] x, input logic [W-1:0] y, input int stall);
    logic [W-1:0] eq, er;
    bit           ee;
    int           lat, cyc;
    model(s, x, y, eq, er, ee, lat);
    check("idle_ready", in_ready, 1);
    is_signed = s;
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    is_signed = 1'($urandom);
    a         = W'($urandom);
    b         = W'($urandom);
    cyc       = 0;
    while (!out_valid && cyc < 100) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 64'(cyc), 64'(lat));
    check("quo", quo, eq);
    check("rem", rem, er);
    check("error", error, ee);
    check("done_busy", in_ready, 0);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_quo", quo, eq);
      check("hold_rem", rem, er);
      check("hold_busy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drop_valid", out_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_error", error, 0);
    check("rst_quo", quo, 0);
    check("rst_rem", rem, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_ignores_ready", out_valid, 0);
    run_op(0, 16'd100, 16'd7, 0);
    run_op(1, 16'hFFF9, 16'd2, 0);
    run_op(1, 16'd7, 16'hFFFE, 0);
    run_op(0, 16'h1234, 16'h0000, 0);
    run_op(1, 16'h1234, 16'h0000, 0);
    run_op(1, 16'h8000, 16'hFFFF, 0);
    run_op(0, 16'h8000, 16'hFFFF, 5);
    run_op(1, 16'h0000, 16'h0005, 0);
    run_op(0, 16'hFFFF, 16'h0001, 1);
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] rx, ry;
      rx = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? '0 :
           ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 9)) : W'($urandom);
      run_op(1'($urandom), rx, ry, $urandom_range(0, 3));
    end
    is_signed = 1'b0;
    a         = 16'hBEEF;
    b         = 16'd3;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_quo", quo, 0);
    check("midrst_rem", rem, 0);
    check("midrst_error", error, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(0, 16'd9, 16'd3, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
